// File: rtl/jtag_pkg.sv
// JTAG master shared types: TAP state encoding, command opcodes, standard instructions, sequence helpers.
// Purely combinational helpers; no latency and no flow control live here.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR, TAP_PAUSE_DR, TAP_EXIT2_DR,
    TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR, TAP_SHIFT_IR, TAP_EXIT1_IR, TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
  } tap_state_t;

  typedef enum logic [1:0] {
    OP_TAP_RESET = 2'b00, OP_IR_SCAN = 2'b01, OP_DR_SCAN = 2'b10, OP_RSVD = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_FIN} mst_state_t;

  typedef struct packed {
    cmd_op_t    op;
    logic [7:0] len;
  } cmd_t;

  localparam logic [3:0] BYPASS  = 4'hF;
  localparam logic [3:0] SAMPLE  = 4'h1;
  localparam logic [3:0] EXTEST  = 4'h2;
  localparam logic [3:0] INTEST  = 4'h3;
  localparam logic [3:0] RUNBIST = 4'h4;
  localparam logic [3:0] CLAMP   = 4'h5;
  localparam logic [3:0] IDCODE  = 4'h7;
  localparam logic [3:0] USERCODE = 4'h8;
  localparam logic [3:0] HIGHZ   = 4'h9;

  function automatic logic is_scan(cmd_op_t op);
    return (op == OP_IR_SCAN) || (op == OP_DR_SCAN);
  endfunction

  // TCK cycles spent walking from Run-Test/Idle into the shift state
  function automatic logic [7:0] pre_len(cmd_op_t op);
    return (op == OP_IR_SCAN) ? 8'd4 : 8'd3;
  endfunction

  function automatic logic [7:0] total_len(cmd_op_t op, logic [7:0] len);
    case (op)
      OP_TAP_RESET: return 8'd6;
      OP_IR_SCAN:   return len + 8'd6;
      OP_DR_SCAN:   return len + 8'd5;
      default:      return 8'd0;
    endcase
  endfunction

  function automatic logic is_shift(cmd_op_t op, logic [7:0] len, logic [7:0] k);
    return is_scan(op) && (k >= pre_len(op)) && (k < pre_len(op) + len);
  endfunction

  function automatic logic tms_at(cmd_op_t op, logic [7:0] len, logic [7:0] k);
    logic [7:0] p;
    p = pre_len(op);
    case (op)
      OP_TAP_RESET:           return k < 8'd5;
      OP_IR_SCAN, OP_DR_SCAN: return (k < p - 8'd2) || ((k >= p + len - 8'd1) && (k <= p + len));
      default:                return 1'b0;
    endcase
  endfunction

  function automatic tap_state_t tap_next(tap_state_t s, logic tms);
    case (s)
      TAP_TLR:      return tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      return tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   return tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   return tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: return tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: return tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: return tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: return tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   return tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   return tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   return tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: return tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: return tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: return tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: return tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   return tms ? TAP_SEL_DR   : TAP_RTI;
      default:      return TAP_TLR;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: CLK_DIV clk low then CLK_DIV clk high; rise/fall strobes mark the clk edge where TCK toggles.
// Idles low with the counter cleared whenever en is low, so the first low phase is always full length.
module jtag_tck_gen
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic TRST,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic       tck_q;

  always_ff @(posedge clk or negedge TRST) begin
    if (!TRST) begin
      cnt_q <= 8'd0;
      tck_q <= 1'b0;
    end else if (!en) begin
      cnt_q <= 8'd0;
      tck_q <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q <= 8'd0;
      tck_q <= ~tck_q;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign rise = en && (cnt_q == LAST) && !tck_q;
  assign fall = en && (cnt_q == LAST) && tck_q;
  assign tck  = tck_q;

endmodule

// File: rtl/jtag_master.sv
// JTAG master: runs TAP reset / IR scan / DR scan commands; done pulses 1 clk after the last TCK fall.
// One command in flight; cmd_ready only in idle. TDO capture built only with JTAG_MASTER_TDO_CAPTURE_EN.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 5,
  parameter int MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_wdata,
  output logic               done,
  output logic [MAX_LEN-1:0] rdata,
  output logic               busy,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  mst_state_t         state_q, state_d;
  cmd_t               cmd_q;
  tap_state_t         tap_q;
  logic [7:0]         total_q, k_q, k_nxt, len_eff;
  logic [MAX_LEN-1:0] wsh_q;
  logic               rise, fall, accept, last;
  logic               pwr_q, done_q, tms_q, tdi_q;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk  (clk),
    .TRST (TRST),
    .en   (state_q == M_RUN),
    .tck  (TCK),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    if (cmd_len == 6'd0)                      len_eff = 8'd1;
    else if ({2'b00, cmd_len} > 8'(MAX_LEN))  len_eff = 8'(MAX_LEN);
    else                                      len_eff = {2'b00, cmd_len};
  end

  assign k_nxt = k_q + 8'd1;
  assign last  = (k_q == total_q - 8'd1);

  always_ff @(posedge clk or negedge TRST) begin
    if (!TRST) state_q <= M_RUN;
    else       state_q <= state_d;
  end

  // The reserved opcode skips the TCK engine entirely and completes via M_FIN.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      M_IDLE: if (cmd_valid) begin
        accept  = 1'b1;
        state_d = (cmd_op_t'(cmd_op) == OP_RSVD) ? M_FIN : M_RUN;
      end
      M_RUN:   if (fall && last) state_d = M_FIN;
      M_FIN:   state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  // Out of reset the sequencer is already loaded with a TAP reset flagged as power-up (no done).
  always_ff @(posedge clk or negedge TRST) begin
    if (!TRST) begin
      cmd_q.op  <= OP_TAP_RESET;
      cmd_q.len <= 8'd0;
      total_q   <= 8'd6;
      k_q       <= 8'd0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      wsh_q     <= '0;
      pwr_q     <= 1'b1;
      done_q    <= 1'b0;
      tap_q     <= TAP_TLR;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        cmd_q.op  <= cmd_op_t'(cmd_op);
        cmd_q.len <= len_eff;
        total_q   <= total_len(cmd_op_t'(cmd_op), len_eff);
        k_q       <= 8'd0;
        tms_q     <= tms_at(cmd_op_t'(cmd_op), len_eff, 8'd0);
        tdi_q     <= 1'b0;
        wsh_q     <= cmd_wdata;
      end
      if (state_q == M_RUN && rise) tap_q <= tap_next(tap_q, tms_q);
      if (state_q == M_RUN && fall) begin
        if (last) begin
          tms_q <= 1'b0;
          tdi_q <= 1'b0;
        end else begin
          k_q   <= k_nxt;
          tms_q <= tms_at(cmd_q.op, cmd_q.len, k_nxt);
          if (is_shift(cmd_q.op, cmd_q.len, k_nxt)) begin
            tdi_q <= wsh_q[0];
            wsh_q <= wsh_q >> 1;
          end else begin
            tdi_q <= 1'b0;
          end
        end
      end
      if (state_q == M_FIN) begin
        pwr_q  <= 1'b0;
        done_q <= !pwr_q;
      end
    end
  end

  assign cmd_ready = (state_q == M_IDLE);
  assign busy      = !cmd_ready;
  assign done      = done_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

`ifdef JTAG_MASTER_TDO_CAPTURE_EN
  logic [MAX_LEN-1:0] cap_q, rdata_q;
  logic [7:0]         align;

  // Bits enter at the top; the final right shift puts the first captured bit at rdata[0].
  assign align = 8'(MAX_LEN) - cmd_q.len;

  always_ff @(posedge clk or negedge TRST) begin
    if (!TRST) begin
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept)
        cap_q <= '0;
      else if (state_q == M_RUN && rise && is_shift(cmd_q.op, cmd_q.len, k_q))
        cap_q <= {TDO, cap_q[MAX_LEN-1:1]};
      if (state_q == M_FIN && !pwr_q && is_scan(cmd_q.op))
        rdata_q <= cap_q >> align;
    end
  end

  assign rdata = rdata_q;
`else
  logic unused_tdo;
  assign unused_tdo = TDO;
  assign rdata      = '0;
`endif

endmodule

// File: doc/jtag_master.md
JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 Parameter CLK_DIV, default 5: TCK half-period in clk cycles; legal range 1..255.
REQ-002 Parameter MAX_LEN, default 32: maximum scan length in bits.
REQ-003 Port clk  input  1  system clock; all logic is synchronous to its rising edge.
REQ-004 Port TRST  input  1  reset, asynchronous, active-low.
REQ-005 Port cmd_valid  input  1  command request.
REQ-006 Port cmd_ready  output  1  master can accept a command.
REQ-007 Port cmd_op  input  2  operation: 00 = TAP reset, 01 = IR scan, 10 = DR scan, 11 = reserved.
REQ-008 Port cmd_len  input  6  scan length in bits.
REQ-009 Port cmd_wdata  input  MAX_LEN  TDI shift data, LSB shifted first.
REQ-010 Port done  output  1  one-clk pulse when a command completes.
REQ-011 Port rdata  output  MAX_LEN  captured TDO bits; bit 0 is the first bit captured.
REQ-012 Port busy  output  1  a command or the power-up sequence is in progress.
REQ-013 Ports TCK, TMS, TDI  output  1 each  JTAG drive lines.
REQ-014 Port TDO  input  1  JTAG return line.

Function
REQ-015 A command SHALL be accepted on a clk edge where cmd_valid and cmd_ready are both 1. The master SHALL register op, len and wdata at acceptance and drop cmd_ready in the next cycle.
REQ-016 Each TCK cycle SHALL be CLK_DIV clk cycles low followed by CLK_DIV clk cycles high.
REQ-017 TMS and TDI SHALL change only at the start of the low phase.
REQ-018 TDO SHALL be sampled on the clk edge at which TCK rises. TCK SHALL idle low.
REQ-019 The master SHALL track a host-side copy of the 16-state TAP FSM. Between commands this copy SHALL be in Run-Test/Idle.
REQ-020 TAP reset: the TMS sequence SHALL be 1,1,1,1,1,0, taking 6 TCK cycles.
REQ-021 IR scan: the TMS sequence SHALL be 1,1,0,0, then len shift bits with TMS=0 on every bit except TMS=1 on the last, then 1,0. Total is len+6 TCK cycles.
REQ-022 DR scan: the TMS sequence SHALL be 1,0,0, then len shift bits as in REQ-021, then 1,0. Total is len+5 TCK cycles.
REQ-023 On shift-bit i, TDI SHALL equal wdata[i]. On every non-shift cycle, TDI SHALL be 0.
REQ-024 For a scan, rdata[i] SHALL equal the TDO sampled on shift-bit i. Bits at len and above SHALL be 0. rdata SHALL be held until the next scan completes.
REQ-025 done SHALL pulse one clk after the final TCK falling edge. cmd_ready SHALL rise in the same cycle as done.
REQ-026 A len of 0 SHALL be executed as len=1. A len greater than MAX_LEN SHALL be clamped to MAX_LEN.
REQ-027 cmd_op=11 SHALL be accepted and complete as a no-op: done pulses 1 clk after acceptance and TCK produces no pulses.
REQ-028 cmd_valid while cmd_ready=0 SHALL be ignored. Back-to-back commands SHALL be accepted on the clk edge where done is high.

Reset
REQ-029 While TRST=0: TCK=0, TMS=1, TDI=0, rdata=0, done=0, cmd_ready=0, busy=1, and the host TAP copy SHALL be Test-Logic-Reset.
REQ-030 After TRST deasserts, the master SHALL autonomously run the REQ-020 sequence. cmd_ready SHALL rise with no done pulse.
REQ-031 TRST asserted mid-command SHALL abort immediately, with no done pulse. REQ-030 SHALL then repeat after release.

Configuration
REQ-032 Macro JTAG_MASTER_TDO_CAPTURE_EN: when defined, TDO capture operates per REQ-024.
REQ-033 When JTAG_MASTER_TDO_CAPTURE_EN is undefined, rdata SHALL be constant 0, TDO SHALL be unused, and all other behaviour SHALL be identical.

Structure
REQ-034 Package jtag_pkg SHALL hold:
- the TAP state enum (16 states, 4-bit encoding);
- the cmd_op codes;
- the instruction constants BYPASS=4'hF, SAMPLE=4'h1, EXTEST=4'h2, INTEST=4'h3, RUNBIST=4'h4, CLAMP=4'h5, IDCODE=4'h7, USERCODE=4'h8, HIGHZ=4'h9.
REQ-035 Sub-module jtag_tck_gen SHALL generate TCK and one-clk rise/fall strobes from CLK_DIV. The master FSM SHALL advance only on these strobes.

Verification
REQ-036 Release TRST -> 6 TCK pulses with TMS=1,1,1,1,1,0, then cmd_ready=1; no done pulse.
REQ-037 IR scan, op=01, len=4, wdata=4'h7, CLK_DIV=5 -> 10 TCK cycles, TMS=1,1,0,0,0,0,0,1,1,0, TDI on shift bits=1,1,1,0, done at clk 101 after acceptance.
REQ-038 DR scan, op=10, len=8, wdata=8'hAD, with TDO tied to TDI -> 13 TCK cycles, rdata=32'h000000AD, done pulse.
REQ-039 TRST asserted at the 5th shift bit of a DR scan -> TCK=0, TMS=1 immediately, no done, REQ-036 sequence after release.
REQ-040 cmd_valid held for two DR scans with len=0 and len=40 -> first runs 6 TCK cycles, second is accepted on its done edge and runs 37 cycles; with the macro undefined, rdata=0 throughout.
